// File: rtl/prefetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_ctrl
// Purpose  : Instruction prefetch controller and memory-port scheduler for the
//            6502 core. Shares one byte-wide memory port between execute-stage
//            data accesses (always preferred) and instruction prefetch. Fetched
//            bytes are held in a circular byte queue whose three head bytes are
//            presented to the decoder.
// Ports    : clk, rst_n                        - clock, async active-low reset
//            mem_req/we/addr/wdata             - request to memory (state-decoded)
//            mem_ready, mem_rvalid, mem_rdata  - memory handshake and read data
//            ex_req/we/addr/wdata              - execute-stage access request
//            ex_ack, ex_rdata                  - execute completion (combinational)
//            q_byte0..2, q_count               - queue head bytes and fill level
//            consume, consume_len, consume_err - byte retirement by the decoder
//            redirect, redirect_pc             - queue flush and fetch restart
//            fetch_pc                          - next byte address to prefetch
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_ctrl #(
  parameter int          QDEPTH   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [15:0]                mem_addr,
  output logic [7:0]                 mem_wdata,
  input  logic                       mem_ready,
  input  logic                       mem_rvalid,
  input  logic [7:0]                 mem_rdata,
  input  logic                       ex_req,
  input  logic                       ex_we,
  input  logic [15:0]                ex_addr,
  input  logic [7:0]                 ex_wdata,
  output logic                       ex_ack,
  output logic [7:0]                 ex_rdata,
  output logic [7:0]                 q_byte0,
  output logic [7:0]                 q_byte1,
  output logic [7:0]                 q_byte2,
  output logic [$clog2(QDEPTH):0]    q_count,
  input  logic                       consume,
  input  logic [1:0]                 consume_len,
  output logic                       consume_err,
  input  logic                       redirect,
  input  logic [15:0]                redirect_pc,
  output logic [15:0]                fetch_pc
);

  localparam int PTRW = $clog2(QDEPTH);
  localparam int CNTW = PTRW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              kind_ex_q, kind_ex_d;   // 1 = execute access, 0 = prefetch
  logic              drop_q, drop_d;         // in-flight prefetch is stale
  logic [15:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [PTRW-1:0]   head_q, head_d;
  logic [PTRW-1:0]   tail_q, tail_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [15:0]       fetch_pc_q, fetch_pc_d;
  logic              consume_err_q, consume_err_d;
  logic [7:0]        storage_q [QDEPTH];

  logic              rsp_done;
  logic              push;
  logic              consume_ok;
  logic [CNTW-1:0]   len_ext;
  logic [PTRW-1:0]   head_p1;
  logic [PTRW-1:0]   head_p2;

  always_comb begin
    state_d       = state_q;
    kind_ex_d     = kind_ex_q;
    drop_d        = drop_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fetch_pc_d    = fetch_pc_q;

    rsp_done      = (state_q == WAIT) && mem_rvalid;
    // A redirect in the completion cycle discards the byte as well.
    push          = rsp_done && !kind_ex_q && !drop_q && !redirect;
    len_ext       = CNTW'(consume_len);
    // Legality is judged against the count before any same-cycle push.
    consume_ok    = consume && !redirect && (consume_len != 2'd0) && (len_ext <= count_q);
    consume_err_d = consume && !redirect && !consume_ok;

    case (state_q)
      IDLE: begin
        if (ex_req) begin
          addr_d    = ex_addr;
          we_d      = ex_we;
          wdata_d   = ex_wdata;
          kind_ex_d = 1'b1;
          state_d   = ISSUE;
        end else if ((count_q < CNTW'(QDEPTH)) && !redirect) begin
          // Only one request is ever outstanding, so a free slot now is
          // still free when the byte returns.
          addr_d    = fetch_pc_q;
          we_d      = 1'b0;
          wdata_d   = 8'h00;
          kind_ex_d = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // The stale prefetch still completes on the bus; its byte is discarded.
    if (redirect && !kind_ex_q &&
        ((state_q == ISSUE) || ((state_q == WAIT) && !mem_rvalid))) begin
      drop_d = 1'b1;
    end

    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (push) begin
        tail_d     = tail_q + PTRW'(1);
        fetch_pc_d = fetch_pc_q + 16'd1;
      end
      if (consume_ok) begin
        head_d = head_q + PTRW'(consume_len);
      end
      count_d = count_q + CNTW'(push) - (consume_ok ? len_ext : CNTW'(0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      kind_ex_q     <= 1'b0;
      drop_q        <= 1'b0;
      addr_q        <= 16'h0000;
      we_q          <= 1'b0;
      wdata_q       <= 8'h00;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_pc_q    <= RESET_PC;
      consume_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_ex_q     <= kind_ex_d;
      drop_q        <= drop_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fetch_pc_q    <= fetch_pc_d;
      consume_err_q <= consume_err_d;
    end
  end

  // Queue payload needs no reset: entries beyond q_count are don't-care.
  always_ff @(posedge clk) begin
    if (push) begin
      storage_q[tail_q] <= mem_rdata;
    end
  end

  assign head_p1     = head_q + PTRW'(1);
  assign head_p2     = head_q + PTRW'(2);

  assign mem_req     = (state_q == ISSUE);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

  assign ex_ack      = (state_q == WAIT) && mem_rvalid && kind_ex_q;
  assign ex_rdata    = mem_rdata;

  assign q_byte0     = storage_q[head_q];
  assign q_byte1     = storage_q[head_p1];
  assign q_byte2     = storage_q[head_p2];
  assign q_count     = count_q;
  assign consume_err = consume_err_q;
  assign fetch_pc    = fetch_pc_q;

endmodule
`default_nettype wire
